// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: FSM encoding, line/beat sizes and beat address helper for the L2 memory arbiter
package l2_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_DONE} state_e;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;
    localparam int LINE_W = 128;
    localparam int WORD_W = 32;

    // Word address of one beat: line tag (addr[31:4]), beat index, byte offset 0
    function automatic logic [WORD_W-1:0] beat_addr(input logic [WORD_W-5:0] tag,
                                                    input logic [BEAT_W-1:0] beat);
        return {tag, beat, 2'b00};
    endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// l2_arb_pick: combinational winner selection, fixed dcache priority or round-robin under L2_ARB_RR_EN
module l2_arb_pick
    import l2_arb_pkg::*;
(
`ifdef L2_ARB_RR_EN
    input  logic last_d_i,
`endif
    input  logic i_req_i,
    input  logic d_req_i,
    output logic any_o,
    output logic pick_d_o
);

    // dcache wins unless icache also waits and (round-robin only) dcache was granted last
    always_comb begin
        any_o = i_req_i | d_req_i;
`ifdef L2_ARB_RR_EN
        pick_d_o = d_req_i & (~i_req_i | ~last_d_i);
`else
        pick_d_o = d_req_i;
`endif
    end

endmodule

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: icache/dcache line transfers over a 4-beat word memory port; L2_ARB_RR_EN selects round-robin arbitration
module l2_mem_arbiter
    import l2_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               icache_r,
    input  logic [WORD_W-1:0]  icache_addr,
    output logic               cache_ready_i,
    input  logic               dcache_r,
    input  logic               dcache_w,
    input  logic [WORD_W-1:0]  dcache_addr,
    input  logic [LINE_W-1:0]  dcache_data_in,
    output logic               cache_ready_d,
    output logic [LINE_W-1:0]  line_data,
    output logic               arb_err,
    input  logic               mem_ready,
    input  logic [WORD_W-1:0]  mem_data,
    output logic [WORD_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_data_out,
    output logic               mem_r,
    output logic               mem_w,
    output logic               busy
);

    state_e                         state_q;
    logic [BEAT_W-1:0]              beat_q;
    logic [BEAT_W-1:0]              beat_n;
    logic [WORD_W-5:0]              tag_q;
    logic                           wr_q;
    logic                           gnt_d_q;
    logic [BEATS-1:0][WORD_W-1:0]   buf_q;
    logic [LINE_W-1:0]              line_q;
    logic                           rdy_i_q;
    logic                           rdy_d_q;
    logic                           err_q;
    logic                           mem_r_q;
    logic                           mem_w_q;
    logic [WORD_W-1:0]              mem_addr_q;
    logic [WORD_W-1:0]              mem_dout_q;
    logic                           any_req;
    logic                           pick_d;
    logic                           unused_offset;
`ifdef L2_ARB_RR_EN
    logic                           last_d_q;
`endif

    // Byte offsets within a line carry no information for line transfers
    assign unused_offset = ^{icache_addr[3:0], dcache_addr[3:0]};
    assign beat_n        = beat_q + 1'b1;

    l2_arb_pick u_pick (
`ifdef L2_ARB_RR_EN
        .last_d_i (last_d_q),
`endif
        .i_req_i  (icache_r),
        .d_req_i  (dcache_r | dcache_w),
        .any_o    (any_req),
        .pick_d_o (pick_d)
    );

    // Transfer FSM with registered memory-side and cache-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            tag_q      <= '0;
            wr_q       <= 1'b0;
            gnt_d_q    <= 1'b0;
            buf_q      <= '0;
            line_q     <= '0;
            rdy_i_q    <= 1'b0;
            rdy_d_q    <= 1'b0;
            err_q      <= 1'b0;
            mem_r_q    <= 1'b0;
            mem_w_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
`ifdef L2_ARB_RR_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            rdy_i_q <= 1'b0;
            rdy_d_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (any_req) begin
                    state_q <= S_GRANT;
                    gnt_d_q <= pick_d;
                    wr_q    <= pick_d & dcache_w;
                    tag_q   <= pick_d ? dcache_addr[WORD_W-1:4] : icache_addr[WORD_W-1:4];
                    err_q   <= pick_d & dcache_r & dcache_w;
                    if (pick_d & dcache_w)
                        buf_q <= dcache_data_in;
`ifdef L2_ARB_RR_EN
                    last_d_q <= pick_d;
`endif
                end
                S_GRANT: begin
                    state_q    <= S_XFER;
                    beat_q     <= '0;
                    mem_r_q    <= ~wr_q;
                    mem_w_q    <= wr_q;
                    mem_addr_q <= beat_addr(tag_q, '0);
                    mem_dout_q <= wr_q ? buf_q[0] : '0;
                end
                S_XFER: if (mem_ready) begin
                    if (!wr_q)
                        buf_q[beat_q] <= mem_data;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_q    <= S_DONE;
                        mem_r_q    <= 1'b0;
                        mem_w_q    <= 1'b0;
                        mem_addr_q <= '0;
                        mem_dout_q <= '0;
                        rdy_i_q    <= ~gnt_d_q;
                        rdy_d_q    <= gnt_d_q;
                        if (!wr_q)
                            line_q <= {mem_data, buf_q[2], buf_q[1], buf_q[0]};
                    end else begin
                        beat_q     <= beat_n;
                        mem_addr_q <= beat_addr(tag_q, beat_n);
                        mem_dout_q <= wr_q ? buf_q[beat_n] : '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cache_ready_i = rdy_i_q;
    assign cache_ready_d = rdy_d_q;
    assign arb_err       = err_q;
    assign line_data     = line_q;
    assign mem_r         = mem_r_q;
    assign mem_w         = mem_w_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data_out  = mem_dout_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: vector table plus tie and mid-transfer reset sequences, checked through beat/ready scoreboards
module tb_l2_mem_arbiter;

    typedef struct {
        logic         ir;
        logic         dr;
        logic         dw;
        logic [31:0]  ia;
        logic [31:0]  da;
        logic [127:0] wd;
        logic [31:0]  base;
        int           stall;
        logic         exp_d;
        int           exp_err;
        int           exp_lat;
    } vec_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic         d;
        logic [127:0] line;
    } done_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         icache_r = 1'b0;
    logic [31:0]  icache_addr = '0;
    logic         cache_ready_i;
    logic         dcache_r = 1'b0;
    logic         dcache_w = 1'b0;
    logic [31:0]  dcache_addr = '0;
    logic [127:0] dcache_data_in = '0;
    logic         cache_ready_d;
    logic [127:0] line_data;
    logic         arb_err;
    logic         mem_ready = 1'b1;
    logic [31:0]  mem_data;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_data_out;
    logic         mem_r;
    logic         mem_w;
    logic         busy;

    beat_t        bq[$];
    done_t        dq[$];
    done_t        de;
    vec_t         vt[7];
    int           n_chk = 0;
    int           n_fail = 0;
    int           err_cnt = 0;
    int           stall_n = 1;
    int           cyc = 0;
    logic [127:0] last_line = '0;
    logic [31:0]  rd_base = '0;

    always #5 clk = ~clk;

    l2_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_r       (icache_r),
        .icache_addr    (icache_addr),
        .cache_ready_i  (cache_ready_i),
        .dcache_r       (dcache_r),
        .dcache_w       (dcache_w),
        .dcache_addr    (dcache_addr),
        .dcache_data_in (dcache_data_in),
        .cache_ready_d  (cache_ready_d),
        .line_data      (line_data),
        .arb_err        (arb_err),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .mem_addr       (mem_addr),
        .mem_data_out   (mem_data_out),
        .mem_r          (mem_r),
        .mem_w          (mem_w),
        .busy           (busy)
    );

    // Memory returns base + beat index; accepts a beat once every stall_n cycles
    assign mem_data = rd_base + {30'b0, mem_addr[3:2]};

    always @(posedge clk) begin
        #1;
        cyc++;
        mem_ready = (stall_n <= 1) || (cyc % stall_n == 0);
    end

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Memory-side and cache-side monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (mem_r && mem_w)
            chk("strobe_exclusive", {mem_r, mem_w}, 2'b00);
        else if (mem_r || mem_w) begin
            if (bq.size() == 0)
                chk("unexpected_beat", {mem_r, mem_w}, 2'b00);
            else begin
                chk("beat", {mem_r, mem_w, mem_addr, (mem_w ? mem_data_out : 32'h0)},
                    {~bq[0].w, bq[0].w, bq[0].a, bq[0].d});
                if (mem_ready)
                    void'(bq.pop_front());
            end
        end
        if (cache_ready_i || cache_ready_d) begin
            if (dq.size() == 0)
                chk("unexpected_ready", {cache_ready_i, cache_ready_d}, 2'b00);
            else begin
                de = dq.pop_front();
                chk("ready", {cache_ready_d, cache_ready_i, line_data}, {de.d, ~de.d, de.line});
            end
        end
        if (arb_err) begin
            err_cnt++;
            chk("err_in_grant", {busy, mem_r, mem_w}, 3'b100);
        end
    end

    task automatic push_xfer(input logic w, input logic d, input logic [31:0] a,
                             input logic [127:0] wd, input logic [31:0] base);
        beat_t        b;
        done_t        e;
        logic [127:0] ln;
        for (int k = 0; k < 4; k++) begin
            b.w = w;
            b.a = {a[31:4], k[1:0], 2'b00};
            b.d = w ? wd[32*k +: 32] : 32'h0;
            bq.push_back(b);
            ln[32*k +: 32] = base + 32'(k);
        end
        e.d    = d;
        e.line = w ? last_line : ln;
        if (!w)
            last_line = ln;
        dq.push_back(e);
    endtask

    task automatic wait_ready(input string nm, input int exp_lat, output logic was_d);
        int lat;
        was_d = 1'b0;
        for (lat = 1; lat <= 500; lat++) begin
            @(posedge clk);
            #1;
            if (cache_ready_i || cache_ready_d)
                break;
        end
        if (lat > 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no ready pulse within 500 cycles", nm);
        end else begin
            was_d = cache_ready_d;
            if (exp_lat > 0)
                chk({nm, "_latency"}, lat, exp_lat);
        end
    endtask

    task automatic drop_all();
        icache_r = 1'b0;
        dcache_r = 1'b0;
        dcache_w = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic who;
        int   e0;
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 128'h0, 32'hA0, 1, 1'b0, 0, 6};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0040,
                  128'h44444444_33333333_22222222_11111111, 32'h0, 3, 1'b1, 0, 0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF8, 128'h0, 32'hDEAD_0000, 1, 1'b1, 0, 6};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h8000_000F, 32'h0, 128'h0, 32'h5A5A_0000, 2, 1'b0, 0, 0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0200,
                  128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 32'h7700_0000, 1, 1'b1, 1, 6};
        vt[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0,
                  128'hCAFE0004_0BAD0003_F00D0002_BEEF0001, 32'h0, 4, 1'b1, 0, 0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 32'h0, 1, 1'b0, 0, 6};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {cache_ready_i, cache_ready_d, arb_err, busy, mem_r, mem_w, mem_addr, mem_data_out}, '0);
        chk("reset_line", line_data, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {busy, mem_r, mem_w}, 3'b000);

        // Simultaneous icache/dcache reads, both held across completions
        stall_n = 1;
        rd_base = 32'hC000_0000;
        push_xfer(1'b0, 1'b1, 32'h0000_0700, '0, rd_base);
`ifdef L2_ARB_RR_EN
        push_xfer(1'b0, 1'b0, 32'h0000_0900, '0, rd_base);
`else
        push_xfer(1'b0, 1'b1, 32'h0000_0700, '0, rd_base);
        push_xfer(1'b0, 1'b0, 32'h0000_0900, '0, rd_base);
`endif
        @(posedge clk);
        #1;
        icache_addr = 32'h0000_0900;
        dcache_addr = 32'h0000_0700;
        icache_r    = 1'b1;
        dcache_r    = 1'b1;
        wait_ready("tie1", 6, who);
        chk("tie1_who", who, 1'b1);
        wait_ready("tie2", 7, who);
`ifdef L2_ARB_RR_EN
        chk("tie2_who", who, 1'b0);
        drop_all();
`else
        chk("tie2_who", who, 1'b1);
        dcache_r = 1'b0;
        wait_ready("tie3", 7, who);
        chk("tie3_who", who, 1'b0);
        drop_all();
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("tie_drained", bq.size() + dq.size(), 0);

        // Table of single-owner transfers
        for (int i = 0; i < 7; i++) begin
            stall_n = vt[i].stall;
            rd_base = vt[i].base;
            e0 = err_cnt;
            push_xfer(vt[i].exp_d & vt[i].dw, vt[i].exp_d, vt[i].exp_d ? vt[i].da : vt[i].ia,
                      vt[i].wd, vt[i].base);
            @(posedge clk);
            #1;
            icache_addr    = vt[i].ia;
            dcache_addr    = vt[i].da;
            dcache_data_in = vt[i].wd;
            icache_r       = vt[i].ir;
            dcache_r       = vt[i].dr;
            dcache_w       = vt[i].dw;
            wait_ready($sformatf("vec%0d", i), vt[i].exp_lat, who);
            chk($sformatf("vec%0d_who", i), who, vt[i].exp_d);
            drop_all();
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_err", i), err_cnt - e0, vt[i].exp_err);
            chk($sformatf("vec%0d_drained", i), bq.size() + dq.size(), 0);
        end

        // Reset while beat 2 of an icache read is on the bus, then restart
        stall_n = 1;
        rd_base = 32'hBEEF_0000;
        push_xfer(1'b0, 1'b0, 32'h0000_0300, '0, rd_base);
        @(posedge clk);
        #1;
        icache_addr = 32'h0000_0300;
        icache_r    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_beat2", {mem_r, mem_addr}, {1'b1, 32'h0000_0308});
        #1;
        rst = 1'b0;
        #1;
        bq.delete();
        dq.delete();
        last_line = '0;
        chk("rst_ctrl", {cache_ready_i, cache_ready_d, arb_err, busy, mem_r, mem_w, mem_addr, mem_data_out}, '0);
        chk("rst_line", line_data, '0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_release_idle", {busy, mem_r, mem_w, cache_ready_i}, 4'b0000);
        push_xfer(1'b0, 1'b0, 32'h0000_0300, '0, rd_base);
        wait_ready("rst_restart", 6, who);
        chk("rst_restart_who", who, 1'b0);
        drop_all();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drained", bq.size() + dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
